// File: rtl/tag_frame_buff.sv
// tag_frame_buff: serializes tagged AXI-Stream frames into READ_WIDTH words
// for a slow microcontroller. Each frame is written as H tag words, W words
// per beat and a beat-count trailer. Frames become visible only once complete;
// a frame that cannot fit is discarded whole.
//
// Ports:
//   clk, rst                     clock, async active-high reset
//   s_axis_tvalid/tready/tdata/
//   s_axis_tuser/tlast           AXI-Stream slave (tuser = tag mask)
//   rd_ena                       read strobe, asynchronous to clk; one pop per rising edge
//   ready                        at least one committed word is unread
//   data_out                     registered head word
//   drop_count, frame_count      only with TAG_FRAME_BUFF_STATS_EN defined
module tag_frame_buff #(
    parameter int unsigned NUM_TAGS      = 20,
    parameter int unsigned NUM_CHANNELS  = 4,
    parameter int unsigned CHANNEL_WIDTH = 64,
    parameter int unsigned FIFO_DEPTH    = 2048,
    parameter int unsigned READ_WIDTH    = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  s_axis_tvalid,
    output logic                                  s_axis_tready,
    input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_TAGS-1:0]                   s_axis_tuser,
    input  logic                                  s_axis_tlast,
    input  logic                                  rd_ena,
    output logic                                  ready,
    output logic [READ_WIDTH-1:0]                 data_out
`ifdef TAG_FRAME_BUFF_STATS_EN
    ,
    output logic [15:0]                           drop_count,
    output logic [15:0]                           frame_count
`endif
);

    localparam int unsigned DATA_WIDTH = NUM_CHANNELS * CHANNEL_WIDTH;
    localparam int unsigned H          = (NUM_TAGS + READ_WIDTH - 1) / READ_WIDTH;
    localparam int unsigned W          = DATA_WIDTH / READ_WIDTH;
    localparam int unsigned AW         = $clog2(FIFO_DEPTH);
    localparam int unsigned IW         = $clog2(H + W + 1);

    typedef enum logic [2:0] {IDLE, HDR, SER, TRL, DROP} state_t;

    state_t                  state, state_n;
    logic [AW-1:0]           spec_ptr, commit_ptr, rd_ptr;
    logic [IW-1:0]           idx;
    logic [DATA_WIDTH-1:0]   tdata_q;
    logic [NUM_TAGS-1:0]     tuser_q;
    logic                    tlast_q;
    logic                    in_frame;
    logic [READ_WIDTH-1:0]   beat_cnt;
    logic [H*READ_WIDTH-1:0] tag_pad;
    logic [READ_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic                    sync1, sync2, sync3;

    logic                    hs, full, pop;
    logic                    latch, wr_due, wr_en, wr_last, do_commit, do_drop, drop_done;
    logic [READ_WIDTH-1:0]   wr_word;

    assign s_axis_tready = ~rst & ((state == IDLE) | (state == DROP));
    assign hs            = s_axis_tvalid & s_axis_tready;
    assign full          = (spec_ptr + AW'(1)) == rd_ptr;
    assign tag_pad       = (H*READ_WIDTH)'(tuser_q);
    assign pop           = sync2 & ~sync3 & (rd_ptr != commit_ptr);
    assign wr_en         = wr_due & ~full;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next state and write control; a write due while full abandons the frame
    always_comb begin
        state_n   = state;
        latch     = 1'b0;
        wr_due    = 1'b0;
        wr_last   = 1'b0;
        wr_word   = '0;
        do_commit = 1'b0;
        do_drop   = 1'b0;
        drop_done = 1'b0;
        case (state)
            IDLE: begin
                if (hs) begin
                    latch   = 1'b1;
                    state_n = in_frame ? SER : HDR;
                end
            end
            HDR: begin
                wr_due  = 1'b1;
                wr_word = tag_pad[idx*READ_WIDTH +: READ_WIDTH];
                if (full)                     do_drop = 1'b1;
                else if (idx == IW'(H - 1))   state_n = SER;
            end
            SER: begin
                wr_due  = 1'b1;
                wr_word = tdata_q[idx*READ_WIDTH +: READ_WIDTH];
                if (full)                     do_drop = 1'b1;
                else if (idx == IW'(W - 1))   state_n = tlast_q ? TRL : IDLE;
            end
            TRL: begin
                wr_due  = 1'b1;
                wr_last = 1'b1;
                wr_word = beat_cnt;
                if (full) begin
                    do_drop = 1'b1;
                end else begin
                    do_commit = 1'b1;
                    state_n   = IDLE;
                end
            end
            DROP: begin
                if (hs && s_axis_tlast) begin
                    drop_done = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (do_drop) state_n = tlast_q ? IDLE : DROP;
    end

    // Datapath: beat latch, pointers, read synchronizer and head register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spec_ptr   <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            idx        <= '0;
            tdata_q    <= '0;
            tuser_q    <= '0;
            tlast_q    <= 1'b0;
            in_frame   <= 1'b0;
            beat_cnt   <= '0;
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync3      <= 1'b0;
            data_out   <= '0;
            ready      <= 1'b0;
        end else begin
            if (latch) begin
                tdata_q  <= s_axis_tdata;
                tuser_q  <= s_axis_tuser;
                tlast_q  <= s_axis_tlast;
                in_frame <= ~s_axis_tlast;
                beat_cnt <= in_frame ? beat_cnt + READ_WIDTH'(1) : READ_WIDTH'(1);
            end else if (drop_done) begin
                in_frame <= 1'b0;
            end
            if (state_n != state) idx <= '0;
            else if (wr_en)       idx <= idx + IW'(1);
            if (do_drop)          spec_ptr <= commit_ptr;
            else if (wr_en)       spec_ptr <= spec_ptr + AW'(1);
            if (do_commit)        commit_ptr <= spec_ptr + AW'(1);
            if (pop)              rd_ptr <= rd_ptr + AW'(1);
            sync1 <= rd_ena;
            sync2 <= sync1;
            sync3 <= sync2;
            // Head word tracks rd_ptr; holds the last value while empty
            if (rd_ptr != commit_ptr) begin
                data_out <= mem[rd_ptr];
                ready    <= 1'b1;
            end else begin
                ready    <= 1'b0;
            end
        end
    end

    // Word storage (not reset)
    always_ff @(posedge clk) begin
        if (wr_en) mem[spec_ptr] <= wr_word;
    end

`ifdef TAG_FRAME_BUFF_STATS_EN
    // Trailer marks let the reader count frames as they drain
    logic trl_mem [FIFO_DEPTH];
    logic pop_trl;

    assign pop_trl = pop & trl_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) trl_mem[spec_ptr] <= wr_last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count  <= '0;
            frame_count <= '0;
        end else begin
            if (do_drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            case ({do_commit, pop_trl})
                2'b10:   frame_count <= frame_count + 16'd1;
                2'b01:   frame_count <= frame_count - 16'd1;
                default: frame_count <= frame_count;
            endcase
        end
    end
`else
    logic unused_last;
    assign unused_last = wr_last;
`endif

endmodule

// File: tb/tb_tag_frame_buff.sv
// Directed bench for tag_frame_buff with FIFO_DEPTH=64 (H=2 tag words, W=16 words/beat).
module tb_tag_frame_buff;

    localparam int unsigned DEPTH = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [255:0] s_axis_tdata;
    logic [19:0]  s_axis_tuser;
    logic         s_axis_tlast;
    logic         rd_ena;
    logic         ready;
    logic [15:0]  data_out;
`ifdef TAG_FRAME_BUFF_STATS_EN
    logic [15:0]  drop_count;
    logic [15:0]  frame_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    tag_frame_buff #(
        .NUM_TAGS(20), .NUM_CHANNELS(4), .CHANNEL_WIDTH(64),
        .FIFO_DEPTH(DEPTH), .READ_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
        .s_axis_tlast(s_axis_tlast),
        .rd_ena(rd_ena), .ready(ready), .data_out(data_out)
`ifdef TAG_FRAME_BUFF_STATS_EN
        , .drop_count(drop_count), .frame_count(frame_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] beat_data(input int b);
        logic [255:0] d;
        for (int i = 0; i < 16; i++) d[16*i +: 16] = 16'hA000 | 16'(b << 8) | 16'(i);
        return d;
    endfunction

    // Expected word image of a frame built with beat_data()
    task automatic push_frame(input int nb, input logic [19:0] u);
        logic [255:0] d;
        exp_q.push_back(u[15:0]);
        exp_q.push_back({12'h000, u[19:16]});
        for (int b = 0; b < nb; b++) begin
            d = beat_data(b);
            for (int i = 0; i < 16; i++) exp_q.push_back(d[16*i +: 16]);
        end
        exp_q.push_back(16'(nb));
    endtask

    task automatic send_beat(input logic [255:0] d, input logic [19:0] u, input logic l);
        int guard;
        guard = 0;
        @(negedge clk);
        s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = l;
        while (!s_axis_tready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) check("tready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 s_axis_tvalid = 1'b0;
    endtask

    task automatic send_frame(input int nb, input logic [19:0] u, input bit push);
        if (push) push_frame(nb, u);
        for (int b = 0; b < nb; b++) send_beat(beat_data(b), u, (b == nb - 1));
        repeat (30) @(negedge clk);
    endtask

    task automatic pop(input int hold);
        @(negedge clk);
        rd_ena = 1'b1;
        repeat (hold) @(negedge clk);
        rd_ena = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic read_words(input int n);
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0) begin
                check("model_underflow", 32'd0, 32'd1);
                return;
            end
            check($sformatf("word%0d", i), 32'(data_out), 32'(exp_q.pop_front()));
            pop(3);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tuser = '0;
        s_axis_tlast = 1'b0; rd_ena = 1'b0;
        repeat (3) @(negedge clk);
        check("tready_in_rst", 32'(s_axis_tready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_tready", 32'(s_axis_tready), 32'd1);

        // 1-beat frame, tuser=0x00005, tdata=1
        send_beat(256'h1, 20'h00005, 1'b1);
        check("t1_ready_before_trl", 32'(ready), 32'd0);
        repeat (30) @(negedge clk);
        check("t1_ready_after_trl", 32'(ready), 32'd1);
        exp_q.push_back(16'h0005);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0001);
        for (int i = 0; i < 15; i++) exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0001);
        read_words(19);
        pop(3);
        check("t1_ready_empty", 32'(ready), 32'd0);
        check("t1_hold_empty", 32'(data_out), 32'h0001);

        // 3-beat frame: 51 words, trailer 3
        send_frame(3, 20'hABCDE, 1'b1);
        check("t2_ready", 32'(ready), 32'd1);
        read_words(51);
        check("t2_ready_empty", 32'(ready), 32'd0);

        // 67-word frame cannot fit in 63 words: dropped, then normal frame
        send_frame(4, 20'h12345, 1'b0);
        check("t3_ready_after_drop", 32'(ready), 32'd0);
`ifdef TAG_FRAME_BUFF_STATS_EN
        check("t3_drop_count", 32'(drop_count), 32'd1);
        check("t3_frame_count0", 32'(frame_count), 32'd0);
`endif
        send_frame(1, 20'h00077, 1'b1);
        check("t3_ready_next", 32'(ready), 32'd1);
`ifdef TAG_FRAME_BUFF_STATS_EN
        check("t3_frame_count1", 32'(frame_count), 32'd1);
`endif
        read_words(19);
        check("t3_ready_empty", 32'(ready), 32'd0);

        // rd_ena held 10 cycles: exactly one pop
        send_frame(1, 20'h00011, 1'b1);
        check("t4_head", 32'(data_out), 32'(exp_q.pop_front()));
        pop(10);
        read_words(18);
        check("t4_ready_empty", 32'(ready), 32'd0);

        // Reset during SER of the second beat
        send_beat(beat_data(0), 20'h00033, 1'b0);
        send_beat(beat_data(1), 20'h00033, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_tready_in_rst", 32'(s_axis_tready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("t5_ready", 32'(ready), 32'd0);
        check("t5_data_out", 32'(data_out), 32'd0);
        check("t5_tready", 32'(s_axis_tready), 32'd1);
        repeat (30) @(negedge clk);
        check("t5_ready_no_ghost", 32'(ready), 32'd0);
        send_frame(2, 20'h0F0F0, 1'b1);
        read_words(35);
        check("t5_ready_empty", 32'(ready), 32'd0);

        // Pop landing on the TRL commit edge of a second frame
        send_frame(1, 20'h00101, 1'b1);
        push_frame(1, 20'h00202);
        check("t6_head", 32'(data_out), 32'(exp_q.pop_front()));
        @(negedge clk);
        s_axis_tvalid = 1'b1; s_axis_tdata = beat_data(0);
        s_axis_tuser = 20'h00202; s_axis_tlast = 1'b1;
        @(posedge clk);
        #1 s_axis_tvalid = 1'b0;
        @(negedge clk);
        repeat (16) @(negedge clk);
        rd_ena = 1'b1;
        repeat (4) @(negedge clk);
        rd_ena = 1'b0;
        repeat (10) @(negedge clk);
        check("t6_ready", 32'(ready), 32'd1);
        read_words(37);
        check("t6_ready_empty", 32'(ready), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tag_frame_buff.md
TAG_FRAME_BUFF -- requirements
Module: tag_frame_buff

Interface
REQ-001 SHALL have parameter NUM_TAGS, default 20, width of the tag mask on s_axis_tuser.
REQ-002 SHALL have parameter NUM_CHANNELS, default 4, number of channels packed per beat.
REQ-003 SHALL have parameter CHANNEL_WIDTH, default 64, bits per channel; DATA_WIDTH = NUM_CHANNELS*CHANNEL_WIDTH.
REQ-004 SHALL have parameter FIFO_DEPTH, default 2048, buffer capacity in READ_WIDTH words, power of two.
REQ-005 SHALL have parameter READ_WIDTH, default 16, microcontroller word width; DATA_WIDTH must be a multiple of READ_WIDTH.
REQ-006 SHALL have port clk, input, 1, sole clock.
REQ-007 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-008 SHALL have ports s_axis_tvalid/s_axis_tready (1 each), s_axis_tdata (DATA_WIDTH), s_axis_tuser (NUM_TAGS) and s_axis_tlast (1), forming an AXI-Stream slave.
REQ-009 SHALL have port rd_ena, input, 1, microcontroller read strobe, asynchronous to clk.
REQ-010 SHALL have port ready, output, 1, high when at least one committed word is unread.
REQ-011 SHALL have port data_out, output, READ_WIDTH, registered head word.

Function
REQ-012 SHALL define H = ceil(NUM_TAGS/READ_WIDTH) and W = DATA_WIDTH/READ_WIDTH.
REQ-013 SHALL serialize each frame into the buffer as: H tag words (tuser of the first beat, LSW first, zero-padded), then W words per beat (LSW first), then one trailer word holding the beat count (modulo 2^READ_WIDTH).
REQ-014 SHALL implement FSM states IDLE, HDR, SER, TRL and DROP; s_axis_tready SHALL be 1 only in IDLE and DROP, and 0 while rst is high.
REQ-015 SHALL, in IDLE, latch a beat on handshake and go to HDR if it is the first beat of a frame, else to SER.
REQ-016 SHALL write one word per cycle in HDR (H cycles, then SER), SER (W cycles, then TRL if the latched tlast is set, else IDLE) and TRL (1 cycle, then IDLE).
REQ-017 SHALL write at a speculative pointer and advance the committed pointer to the speculative pointer only in the TRL cycle, so that ready and reads see whole frames only.
REQ-018 SHALL, when a write is due while the speculative pointer is one word short of the read pointer (full), rewind the speculative pointer to the committed pointer and abandon the frame: go to DROP, or to IDLE if the latched beat had tlast set.
REQ-019 SHALL, in DROP, accept and discard beats until a tlast handshake, then go to IDLE.
REQ-020 SHALL drop any frame larger than FIFO_DEPTH-1 words and continue to operate normally afterwards.
REQ-021 SHALL pass rd_ena through a 2-flop synchronizer and pop exactly one word on each synchronized rising edge; a pop while empty SHALL be ignored.
REQ-022 SHALL update data_out to the new head word no later than 3 clk cycles after the synchronized edge; data_out SHALL hold its value while empty.
REQ-023 SHALL allow a commit and a pop in the same cycle with both taking effect.

Reset
REQ-024 SHALL, on rst, set all pointers to 0, the FSM to IDLE, data_out to 0 and ready to 0, and clear the synchronizer flops.
REQ-025 SHALL discard committed and uncommitted data if rst asserts mid-frame; the first beat after reset SHALL start a new frame.

Configuration
REQ-026 SHALL, with macro TAG_FRAME_BUFF_STATS_EN defined, add output drop_count (16 bits, increments once per dropped frame, saturates at 0xFFFF, reset to 0) and output frame_count (16 bits, committed-but-unread frames).
REQ-027 SHALL, without TAG_FRAME_BUFF_STATS_EN, omit both ports and their logic, with otherwise identical behaviour.

Verification
REQ-028 SHALL cover: one 1-beat frame with tuser=0x00005, tdata=0x...0001 -> ready rises after TRL; 20 pops read 0x0005, 0x0000, 16 data words, 0x0001, then ready=0.
REQ-029 SHALL cover: a 3-beat frame -> 2+48+1 = 51 words read back in order, trailer 0x0003.
REQ-030 SHALL cover: FIFO_DEPTH=64 with a 4-beat frame (67 words) -> frame dropped, ready stays 0, drop_count=1 (stats build), a following 1-beat frame reads back intact.
REQ-031 SHALL cover: rd_ena held high for 10 cycles -> exactly one pop.
REQ-032 SHALL cover: rst pulse during SER of the second beat -> ready=0, data_out=0, tready=1 after release, a new frame reads back correctly.
REQ-033 SHALL cover: a pop coincident with the TRL commit -> no word lost or duplicated, ready stays 1.
